// File: rtl/dma_pkg.sv
// Shared constants, register map, configuration payload and FSM encoding for the word-copy DMA.
package dma_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_IDLE  = 2'b00;
    localparam logic [MODE_W-1:0] MODE_READ  = 2'b01;
    localparam logic [MODE_W-1:0] MODE_WRITE = 2'b10;
    localparam logic [MODE_W-1:0] REQW_WORD  = 2'b10;

    // Word index of each register inside the 4-word window
    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;
    localparam int unsigned CTRL_BUSY   = 8;
    localparam int unsigned CTRL_DONE   = 9;

    typedef struct packed {
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dst;
        logic [LEN_W-1:0]  len;
    } dma_cfg_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RD,
        ST_RDW,
        ST_WR,
        ST_GAP,
        ST_DONE
    } dma_state_e;

endpackage

// File: rtl/dma_if.sv
// DMA master-port bundle: bus arbitration handshake with the core plus the master-mux data path.
interface dma_if;
    import dma_pkg::*;

    logic              cpu_hold;
    logic              hold_ack;
    logic              bus_owner;
    logic [ADDR_W-1:0] m_addr;
    logic [MODE_W-1:0] m_mode;
    logic [MODE_W-1:0] m_reqw;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    modport master (
        output cpu_hold, bus_owner, m_addr, m_mode, m_reqw, m_wdata,
        input  hold_ack, m_rdata
    );

    modport slave (
        input  cpu_hold, bus_owner, m_addr, m_mode, m_reqw, m_wdata,
        output hold_ack, m_rdata
    );

endinterface

// File: rtl/dma_regs.sv
// CPU-visible register window: decode, register file, tri-state read driver, DONE/IRQ bookkeeping.
module dma_regs
    import dma_pkg::*;
#(
    parameter logic [ADDR_W-1:0] base_address = 32'h40C0
) (
    input  logic              clk,
    input  logic              reset,
    inout  wire  [DATA_W-1:0] data_bus_data,
    input  logic [ADDR_W-1:0] data_bus_addr,
    input  logic [MODE_W-1:0] data_bus_mode,
    input  logic              busy_c,
    input  logic              done_set_c,
    output logic              start_c,
    output dma_cfg_t          cfg,
    output logic              dma_irq
);

    logic              hit_c;
    logic              wr_c;
    logic              rd_c;
    logic [1:0]        sel_c;
    logic [DATA_W-1:0] wdata_c;
    logic [DATA_W-1:0] rdata_c;

    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              irq_en_q, irq_en_d;
    logic              done_q, done_d;
    logic              irq_q, irq_d;

    assign hit_c   = (data_bus_addr[ADDR_W-1:4] == base_address[ADDR_W-1:4])
                  && (data_bus_addr[1:0] == 2'b00);
    assign sel_c   = data_bus_addr[3:2];
    assign wr_c    = hit_c && (data_bus_mode == MODE_WRITE);
    assign rd_c    = hit_c && (data_bus_mode == MODE_READ);
    assign wdata_c = data_bus_data;

    // Setup registers are frozen while a transfer runs; IRQ_EN and the DONE clear stay live
    always_comb begin
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        irq_en_d = irq_en_q;
        done_d   = done_q;
        start_c  = 1'b0;
        if (wr_c && !busy_c) begin
            case (sel_c)
                REG_SRC: src_d = {wdata_c[ADDR_W-1:2], 2'b00};
                REG_DST: dst_d = {wdata_c[ADDR_W-1:2], 2'b00};
                REG_LEN: len_d = wdata_c[LEN_W-1:0];
                default: ;
            endcase
        end
        if (wr_c && (sel_c == REG_CTRL)) begin
            irq_en_d = wdata_c[CTRL_IRQ_EN];
            if (wdata_c[CTRL_DONE]) begin
                done_d = 1'b0;
            end
            if (wdata_c[CTRL_START] && !busy_c) begin
                start_c = 1'b1;
                done_d  = (len_q == LEN_W'(0));
            end
        end
        if (done_set_c) begin
            done_d = 1'b1;
        end
        irq_d = done_d & irq_en_d;
    end

    always_comb begin
        rdata_c = '0;
        case (sel_c)
            REG_SRC: rdata_c = src_q;
            REG_DST: rdata_c = dst_q;
            REG_LEN: rdata_c = DATA_W'(len_q);
            default: begin
                rdata_c[CTRL_IRQ_EN] = irq_en_q;
                rdata_c[CTRL_BUSY]   = busy_c;
                rdata_c[CTRL_DONE]   = done_q;
            end
        endcase
    end

    assign data_bus_data = rd_c ? rdata_c : {DATA_W{1'bz}};

    always_ff @(posedge clk) begin
        if (reset) begin
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            irq_q    <= irq_d;
        end
    end

    assign cfg.src = src_q;
    assign cfg.dst = dst_q;
    assign cfg.len = len_q;
    assign dma_irq = irq_q;

endmodule

// File: rtl/dma_controller.sv
// Word-copy DMA engine: requests the bus from the core, moves words in bounded bursts, then signals completion.
module dma_controller
    import dma_pkg::*;
#(
    parameter logic [ADDR_W-1:0] base_address = 32'h40C0,
    parameter int unsigned       burst_len    = 8,
    parameter int unsigned       gap_cycles   = 4
) (
    input  logic              clk,
    input  logic              reset,
    inout  wire  [DATA_W-1:0] data_bus_data,
    input  logic [ADDR_W-1:0] data_bus_addr,
    input  logic [MODE_W-1:0] data_bus_mode,
    dma_if.master             m,
    output logic              dma_irq
);

    localparam int unsigned BCNT_W = $clog2(burst_len + 1);
    localparam int unsigned GCNT_W = $clog2(gap_cycles + 1);

    dma_state_e state_q, state_d;

    logic [ADDR_W-1:0] cur_src_q, cur_src_d;
    logic [ADDR_W-1:0] cur_dst_q, cur_dst_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [GCNT_W-1:0] gcnt_q, gcnt_d;

    logic              cpu_hold_q, cpu_hold_d;
    logic              bus_owner_q, bus_owner_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [MODE_W-1:0] m_mode_q, m_mode_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;

    logic     busy_c;
    logic     done_set_c;
    logic     start_c;
    dma_cfg_t cfg;

    dma_regs #(
        .base_address (base_address)
    ) u_regs (
        .clk           (clk),
        .reset         (reset),
        .data_bus_data (data_bus_data),
        .data_bus_addr (data_bus_addr),
        .data_bus_mode (data_bus_mode),
        .busy_c        (busy_c),
        .done_set_c    (done_set_c),
        .start_c       (start_c),
        .cfg           (cfg),
        .dma_irq       (dma_irq)
    );

    assign busy_c     = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done_set_c = (state_q == ST_WR) && (state_d == ST_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A start landing in the DONE cycle is honoured like one in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start_c && (cfg.len != LEN_W'(0))) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (m.hold_ack) begin
                    state_d = ST_RD;
                end
            end
            ST_RD:  state_d = ST_RDW;
            ST_RDW: state_d = ST_WR;
            ST_WR: begin
                if (rem_q == LEN_W'(1)) begin
                    state_d = ST_DONE;
                end else if (bcnt_q == BCNT_W'(burst_len - 1)) begin
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_RD;
                end
            end
            ST_GAP: begin
                if (gcnt_q == GCNT_W'(0)) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Working copies of the setup registers; the user-visible ones are never touched
    always_comb begin
        cur_src_d = cur_src_q;
        cur_dst_d = cur_dst_q;
        rem_d     = rem_q;
        bcnt_d    = bcnt_q;
        gcnt_d    = gcnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_c) begin
                    cur_src_d = cfg.src;
                    cur_dst_d = cfg.dst;
                    rem_d     = cfg.len;
                    bcnt_d    = BCNT_W'(0);
                end
            end
            ST_WR: begin
                cur_src_d = cur_src_q + ADDR_W'(4);
                cur_dst_d = cur_dst_q + ADDR_W'(4);
                rem_d     = rem_q - LEN_W'(1);
                bcnt_d    = bcnt_q + BCNT_W'(1);
                if (state_d == ST_GAP) begin
                    bcnt_d = BCNT_W'(0);
                    gcnt_d = GCNT_W'(gap_cycles - 1);
                end
            end
            ST_GAP: begin
                if (gcnt_q != GCNT_W'(0)) begin
                    gcnt_d = gcnt_q - GCNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the registered state
    always_comb begin
        cpu_hold_d  = 1'b0;
        bus_owner_d = 1'b0;
        m_mode_d    = MODE_IDLE;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        case (state_d)
            ST_REQ: cpu_hold_d = 1'b1;
            ST_RD: begin
                cpu_hold_d  = 1'b1;
                bus_owner_d = 1'b1;
                m_mode_d    = MODE_READ;
                m_addr_d    = cur_src_d;
            end
            ST_RDW: begin
                cpu_hold_d  = 1'b1;
                bus_owner_d = 1'b1;
            end
            ST_WR: begin
                cpu_hold_d  = 1'b1;
                bus_owner_d = 1'b1;
                m_mode_d    = MODE_WRITE;
                m_addr_d    = cur_dst_d;
                m_wdata_d   = m.m_rdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_src_q   <= '0;
            cur_dst_q   <= '0;
            rem_q       <= '0;
            bcnt_q      <= '0;
            gcnt_q      <= '0;
            cpu_hold_q  <= 1'b0;
            bus_owner_q <= 1'b0;
            m_addr_q    <= '0;
            m_mode_q    <= MODE_IDLE;
            m_wdata_q   <= '0;
        end else begin
            cur_src_q   <= cur_src_d;
            cur_dst_q   <= cur_dst_d;
            rem_q       <= rem_d;
            bcnt_q      <= bcnt_d;
            gcnt_q      <= gcnt_d;
            cpu_hold_q  <= cpu_hold_d;
            bus_owner_q <= bus_owner_d;
            m_addr_q    <= m_addr_d;
            m_mode_q    <= m_mode_d;
            m_wdata_q   <= m_wdata_d;
        end
    end

    assign m.cpu_hold  = cpu_hold_q;
    assign m.bus_owner = bus_owner_q;
    assign m.m_addr    = m_addr_q;
    assign m.m_mode    = m_mode_q;
    assign m.m_reqw    = REQW_WORD;
    assign m.m_wdata   = m_wdata_q;

endmodule

// File: tb/tb_dma_controller.sv
// Randomized scoreboard bench for dma_controller: expected bus traffic is queued at start, a monitor pops and compares.
module tb_dma_controller;
    import dma_pkg::*;

    localparam logic [31:0] BASE   = 32'h40C0;
    localparam int          BURST  = 8;
    localparam int          GAP    = 4;
    localparam logic [31:0] A_SRC  = BASE;
    localparam logic [31:0] A_DST  = BASE + 32'd4;
    localparam logic [31:0] A_LEN  = BASE + 32'd8;
    localparam logic [31:0] A_CTRL = BASE + 32'd12;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    wire  [31:0] data_bus_data;
    logic [31:0] data_bus_addr = '0;
    logic [1:0]  data_bus_mode = MODE_IDLE;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_oe = 1'b0;
    logic        dma_irq;
    logic        hold_ack = 1'b0;
    logic [31:0] salt = '0;
    int          ack_dly = 1;
    int          ack_cnt = 0;
    logic        mon_en = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_rd_q[$];
    wr_t         exp_wr_q[$];
    int          exp_burst_q[$];

    // Source memory content is a fixed hash of the address, re-salted per transfer
    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] k);
        return (a * 32'h9E37_79B1) ^ k;
    endfunction

    dma_if bus_if ();

    assign data_bus_data   = cpu_oe ? cpu_wdata : {32{1'bz}};
    assign bus_if.hold_ack = hold_ack;
    assign bus_if.m_rdata  = mem_word(bus_if.m_addr, salt);

    dma_controller #(
        .base_address (BASE),
        .burst_len    (BURST),
        .gap_cycles   (GAP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .data_bus_data (data_bus_data),
        .data_bus_addr (data_bus_addr),
        .data_bus_mode (data_bus_mode),
        .m             (bus_if),
        .dma_irq       (dma_irq)
    );

    always #5 clk = ~clk;

    // Core model: grants the bus ack_dly cycles after cpu_hold rises
    always @(posedge clk) begin
        #1;
        if (reset || !bus_if.cpu_hold) begin
            ack_cnt  = 0;
            hold_ack = 1'b0;
        end else begin
            ack_cnt++;
            hold_ack = (ack_cnt >= ack_dly);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic reg_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        data_bus_addr = a;
        data_bus_mode = MODE_WRITE;
        cpu_wdata     = d;
        cpu_oe        = 1'b1;
        @(posedge clk); #1;
        data_bus_mode = MODE_IDLE;
        cpu_oe        = 1'b0;
    endtask

    task automatic reg_read(input logic [31:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        data_bus_addr = a;
        data_bus_mode = MODE_READ;
        cpu_oe        = 1'b0;
        #3;
        d = data_bus_data;
        @(posedge clk); #1;
        data_bus_mode = MODE_IDLE;
    endtask

    // Reference model: word i reads src+4i and writes that word to dst+4i, grouped in bursts of at most BURST
    task automatic program_copy(input logic [31:0] src, input logic [31:0] dst, input int len, input logic ien);
        logic [31:0] s;
        logic [31:0] d;
        wr_t         w;
        int          rem;
        s       = {src[31:2], 2'b00};
        d       = {dst[31:2], 2'b00};
        salt    = $urandom;
        ack_dly = $urandom_range(1, 4);
        for (int i = 0; i < len; i++) begin
            exp_rd_q.push_back(s + 32'(4 * i));
            w.addr = d + 32'(4 * i);
            w.data = mem_word(s + 32'(4 * i), salt);
            exp_wr_q.push_back(w);
        end
        rem = len;
        while (rem > 0) begin
            exp_burst_q.push_back(rem > BURST ? BURST : rem);
            rem -= (rem > BURST ? BURST : rem);
        end
        reg_write(A_SRC, src);
        reg_write(A_DST, dst);
        reg_write(A_LEN, 32'(len));
        reg_write(A_CTRL, {30'b0, ien, 1'b1});
    endtask

    task automatic wait_done(input string name);
        logic [31:0] v;
        int          n;
        v = '0;
        n = 0;
        while (!v[CTRL_DONE] && n < 4000) begin
            reg_read(A_CTRL, v);
            n++;
        end
        check({name, "_done"}, 32'(v[CTRL_DONE]), 32'd1);
        check({name, "_busy"}, 32'(v[CTRL_BUSY]), 32'd0);
        check({name, "_rd_drain"}, 32'(exp_rd_q.size()), 32'd0);
        check({name, "_wr_drain"}, 32'(exp_wr_q.size()), 32'd0);
        check({name, "_burst_drain"}, 32'(exp_burst_q.size()), 32'd0);
    endtask

    task automatic count_hold(input int cycles, output int highs);
        highs = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (bus_if.cpu_hold) highs++;
        end
    endtask

    // Monitor: pops the scoreboard whenever the master port shows a transaction
    int   burst_words = 0;
    int   gap_len = 0;
    logic gapping = 1'b0;
    logic prev_owner = 1'b0;

    always @(negedge clk) begin
        if (!mon_en) begin
            burst_words = 0;
            gap_len     = 0;
            gapping     = 1'b0;
            prev_owner  = bus_if.bus_owner;
        end else begin
            if (bus_if.m_mode != MODE_IDLE) begin
                check("m_reqw", 32'(bus_if.m_reqw), 32'(REQW_WORD));
                check("owner_during_xfer", 32'(bus_if.bus_owner), 32'd1);
            end
            if (bus_if.m_mode == MODE_READ) begin
                if (exp_rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected: got read at 0x%08h, expected no read", bus_if.m_addr);
                end else begin
                    check("rd_addr", bus_if.m_addr, exp_rd_q.pop_front());
                end
            end
            if (bus_if.m_mode == MODE_WRITE) begin
                burst_words++;
                if (exp_wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_unexpected: got write at 0x%08h, expected no write", bus_if.m_addr);
                end else begin
                    wr_t w;
                    w = exp_wr_q.pop_front();
                    check("wr_addr", bus_if.m_addr, w.addr);
                    check("wr_data", bus_if.m_wdata, w.data);
                end
            end
            if (prev_owner && !bus_if.bus_owner) begin
                check("hold_drops_with_owner", 32'(bus_if.cpu_hold), 32'd0);
                if (exp_burst_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL burst_unexpected: got burst of %0d words, expected none", burst_words);
                end else begin
                    check("burst_words", 32'(burst_words), 32'(exp_burst_q.pop_front()));
                end
                burst_words = 0;
                if (exp_wr_q.size() != 0) begin
                    gapping = 1'b1;
                    gap_len = 0;
                end
            end
            if (gapping) begin
                if (bus_if.cpu_hold) begin
                    check("gap_min_cycles", 32'(gap_len >= GAP), 32'd1);
                    gapping = 1'b0;
                end else begin
                    gap_len++;
                end
            end
            prev_owner = bus_if.bus_owner;
        end
    end

    initial begin
        logic [31:0] v;
        logic [31:0] src;
        logic [31:0] dst;
        logic        ien;
        int          n;
        int          highs;
        logic        seen;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_cpu_hold", 32'(bus_if.cpu_hold), 32'd0);
        check("rst_bus_owner", 32'(bus_if.bus_owner), 32'd0);
        check("rst_m_mode", 32'(bus_if.m_mode), 32'd0);
        check("rst_m_addr", bus_if.m_addr, 32'd0);
        check("rst_m_wdata", bus_if.m_wdata, 32'd0);
        check("rst_irq", 32'(dma_irq), 32'd0);
        reg_read(A_SRC, v);  check("rst_src", v, 32'd0);
        reg_read(A_DST, v);  check("rst_dst", v, 32'd0);
        reg_read(A_LEN, v);  check("rst_len", v, 32'd0);
        reg_read(A_CTRL, v); check("rst_ctrl", v, 32'd0);
        mon_en = 1'b1;

        // Basic copy with interrupt, then W1C
        program_copy(32'h0000_1000, 32'h0000_2000, 3, 1'b1);
        wait_done("basic");
        check("basic_irq", 32'(dma_irq), 32'd1);
        reg_write(A_CTRL, 32'h0000_0202);
        check("w1c_irq", 32'(dma_irq), 32'd0);
        reg_read(A_CTRL, v);
        check("w1c_ctrl", v, 32'h0000_0002);

        // Zero length: DONE without any bus request
        reg_write(A_LEN, 32'd0);
        reg_write(A_CTRL, 32'h0000_0001);
        reg_read(A_CTRL, v);
        check("zero_ctrl", v, 32'h0000_0200);
        count_hold(8, highs);
        check("zero_no_hold", 32'(highs), 32'd0);

        // Bursts 8/8/4 with a protected-register attempt during the first gap
        src = $urandom & 32'h00FF_FFFC;
        dst = $urandom & 32'h00FF_FFFC;
        program_copy(src, dst, 20, 1'b1);
        seen = 1'b0;
        n    = 0;
        while (n < 1000) begin
            @(posedge clk); #1;
            n++;
            if (bus_if.cpu_hold) seen = 1'b1;
            else if (seen) break;
        end
        check("gap_reached", 32'(n < 1000), 32'd1);
        reg_write(A_SRC, 32'hDEAD_0000);
        reg_write(A_CTRL, 32'h0000_0003);
        reg_read(A_SRC, v);
        check("busy_src_kept", v, src);
        wait_done("burst");
        check("burst_irq", 32'(dma_irq), 32'd1);
        count_hold(20, highs);
        check("burst_no_restart", 32'(highs), 32'd0);

        // Unaligned source near the top of the address space
        program_copy(32'hFFFF_FFFE, 32'h0000_3000, 2, 1'b0);
        wait_done("wrap");
        reg_read(A_SRC, v);
        check("wrap_src_aligned", v, 32'hFFFF_FFFC);
        check("wrap_irq", 32'(dma_irq), 32'd0);

        // Random transfers
        for (int t = 0; t < 4; t++) begin
            src = $urandom;
            dst = $urandom;
            ien = 1'($urandom);
            program_copy(src, dst, $urandom_range(1, 19), ien);
            wait_done("rand");
            check("rand_irq", 32'(dma_irq), 32'(ien));
            reg_write(A_CTRL, 32'h0000_0200);
            check("rand_irq_clr", 32'(dma_irq), 32'd0);
        end

        // Reset while the DMA owns the bus
        program_copy(32'h0000_5000, 32'h0000_6000, 10, 1'b1);
        n = 0;
        while (bus_if.m_mode != MODE_READ && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("mid_rd_reached", 32'(n < 200), 32'd1);
        mon_en = 1'b0;
        reset  = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_hold", 32'(bus_if.cpu_hold), 32'd0);
        check("mid_rst_owner", 32'(bus_if.bus_owner), 32'd0);
        check("mid_rst_mode", 32'(bus_if.m_mode), 32'd0);
        check("mid_rst_irq", 32'(dma_irq), 32'd0);
        reset = 1'b0;
        exp_rd_q.delete();
        exp_wr_q.delete();
        exp_burst_q.delete();
        reg_read(A_CTRL, v);
        check("mid_rst_ctrl", v, 32'd0);
        count_hold(6, highs);
        check("mid_rst_idle", 32'(highs), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
